timer_irq_ctrl: RTL and testbench
=================================

// Module: timer_irq_ctrl
// PURPOSE
//  Consumes the single-cycle irq pulses of up to 8 timer/big_timer instances and latches each
//  into a sticky pending bit. Exposes pending/mask/ack over an Avalon-MM slave so NIOS II software
//  services timer ticks. Drives one level interrupt to the CPU IRQ line; optionally counts missed ticks.
// PARAMETERS
//  N_SRC   4   number of tick sources, 1..8
//  MISS_W  8   width of each missed-tick counter (saturating), 1..32
// PORTS
//  clk             in   1      system clock (50 MHz)
//  reset_n         in   1      asynchronous, active-low reset
//  tick            in   N_SRC  timer irq outputs; every cycle a bit is high counts as one event
//  avs_address     in   4      word address
//  avs_chipselect  in   1      slave select
//  avs_read        in   1      read strobe (valid with chipselect)
//  avs_write       in   1      write strobe (valid with chipselect)
//  avs_writedata   in   32     write data
//  avs_readdata    out  32     read data, registered, read latency 1
//  irq             out  1      level interrupt to CPU, registered
// BEHAVIOUR
//  - Reset (async assert, sync release): pending=0, mask=0, miss counters=0, irq=0, avs_readdata=0.
//  - Register map (word addr): 0 PENDING RO | 1 MASK RW | 2 ACK W1C, reads 0 | 3 STATUS RO
//    {31'b0, irq} | 8+i MISS[i] RO, zero-extended (only with macro). Unused/out-of-range addrs read 0,
//    writes ignored. Bits >= N_SRC read 0, write-ignored.
//  - Pending per source i, evaluated every clk edge:
//      tick[i]=1                -> pending[i] <= 1 (set wins over a same-cycle ACK write)
//      tick[i]=0 & ACK bit i=1  -> pending[i] <= 0
//      else                     -> hold
//  - Masking never blocks latching: a masked source still sets pending.
//  - irq <= |(pending & mask), using the register values before the current edge updates them.
//    Tick at cycle T -> pending at T+1 -> irq at T+2.
//    ACK or MASK write at T -> irq deasserts at T+2 if nothing else is pending & enabled.
//  - Read: chipselect & read at T -> avs_readdata valid at T+1, sampling register values at T.
//    Otherwise avs_readdata holds its last value. No waitrequest; a write is accepted every cycle.
//  - Read and write in the same cycle: the write is performed and the read returns the pre-write value.
//  - tick held high continuously (timer divider=0): pending stays 1; an ACK has no effect while it is high.
// CONFIGURATION
//  - Macro TIMER_IRQ_MISS_CNT_EN
//  - Defined: per-source MISS[i] counter.
//      Increment: tick[i]=1 while pending[i]=1 and no same-cycle ACK of bit i.
//      Saturates at 2^MISS_W-1 (no wrap).
//      ACK bit i sets MISS[i] to 0. If tick[i] is also high that cycle, the tick is not a miss and the count stays 0.
//  - Undefined: counters absent; addrs 8..15 read 0.
// STRUCTURE
//  - Package timer_irq_pkg:
//      localparams ADDR_PENDING=0, ADDR_MASK=1, ADDR_ACK=2, ADDR_STATUS=3, ADDR_MISS_BASE=8.
//      MAX_SRC=8.
//      typedef of the 4-bit address.
//  - Sub-module timer_irq_slot: one pending bit plus the optional miss counter; inputs tick, ack;
//    generated N_SRC times. Top level holds mask, irq, the address decode and the readdata mux.
// TESTING
//  - Reset mid-run, pending=4'hF and irq=1: assert reset_n=0 -> irq, readdata, pending and mask are 0
//    immediately (async) and stay 0 after release.
//  - MASK=4'h2; tick[1] pulse at T -> PENDING reads 4'h2; irq=1 at T+2.
//    Then ACK 4'h2 -> PENDING=0; irq=0 two cycles after the write.
//  - MASK=0; tick[0] pulse -> PENDING=4'h1, irq stays 0.
//    Then write MASK=4'h1 -> irq=1 two cycles later.
//  - ACK 4'h1 in the same cycle as a tick[0] pulse -> PENDING bit 0 stays 1; MISS[0] reads 0.
//  - [MISS_CNT_EN] tick[2] pulsed 300 times with no ACK, MISS_W=8 -> MISS[2]=255 (saturated).
//    Then ACK 4'h4 -> MISS[2]=0, PENDING bit 2 = 0.
//  - Read addr 2, addr 5 and addr 9 without the macro -> 0.
//    Read with a simultaneous MASK write -> returns the old MASK value.

Source files
------------

// File: rtl/timer_irq_pkg.sv
// Shared constants and types for the timer interrupt controller: register map and bus address type.
package timer_irq_pkg;

  typedef logic [3:0] addr_t;

  localparam addr_t ADDR_PENDING   = 4'd0;
  localparam addr_t ADDR_MASK      = 4'd1;
  localparam addr_t ADDR_ACK       = 4'd2;
  localparam addr_t ADDR_STATUS    = 4'd3;
  localparam addr_t ADDR_MISS_BASE = 4'd8;

  localparam int MAX_SRC = 8;

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// Avalon-MM slave bus for timer_irq_ctrl.
// Handshake: a transfer happens on every clock edge where chipselect is high together with
// read or write; there is no waitrequest, and read data appears one cycle after the read strobe.
interface timer_irq_ctrl_if;
  import timer_irq_pkg::*;

  addr_t       address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );

endinterface

// File: rtl/timer_irq_slot.sv
// One tick source: sticky pending bit and, with TIMER_IRQ_MISS_CNT_EN, a saturating missed-tick counter.
module timer_irq_slot
`ifdef TIMER_IRQ_MISS_CNT_EN
  #(parameter int MISS_W = 8)
`endif
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              ack,
`ifdef TIMER_IRQ_MISS_CNT_EN
  output logic [MISS_W-1:0] miss,
`endif
  output logic              pending
);

  // A tick always wins over an acknowledge in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
    end else if (tick) begin
      pending <= 1'b1;
    end else if (ack) begin
      pending <= 1'b0;
    end
  end

`ifdef TIMER_IRQ_MISS_CNT_EN
  // A tick arriving while the previous one is still unserviced is a miss, unless acked this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss <= '0;
    end else if (ack) begin
      miss <= '0;
    end else if (tick && pending && (miss != {MISS_W{1'b1}})) begin
      miss <= miss + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt aggregator: latches tick pulses into pending bits, exposes them over Avalon-MM,
// drives a level irq. Optional missed-tick counters with macro TIMER_IRQ_MISS_CNT_EN.
module timer_irq_ctrl
  import timer_irq_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int MISS_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] tick,
  timer_irq_ctrl_if.slave  avs,
  output logic             irq
);

  if (N_SRC < 1 || N_SRC > MAX_SRC) begin : g_bad_n_src
    $error("timer_irq_ctrl: N_SRC out of range");
  end
  if (MISS_W < 1 || MISS_W > 32) begin : g_bad_miss_w
    $error("timer_irq_ctrl: MISS_W out of range");
  end

  logic             wr_en;
  logic             rd_en;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] ack_vec;
  logic [31:0]      rd_val;
  logic             unused_wdata;

  assign wr_en        = avs.chipselect & avs.write;
  assign rd_en        = avs.chipselect & avs.read;
  assign ack_vec      = (wr_en && avs.address == ADDR_ACK) ? avs.writedata[N_SRC-1:0] : '0;
  assign unused_wdata = ^avs.writedata[31:N_SRC];

`ifdef TIMER_IRQ_MISS_CNT_EN
  logic [MISS_W-1:0] miss [N_SRC];
`endif

  for (genvar i = 0; i < N_SRC; i++) begin : g_slot
    timer_irq_slot
`ifdef TIMER_IRQ_MISS_CNT_EN
      #(.MISS_W(MISS_W))
`endif
    u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick[i]),
      .ack     (ack_vec[i]),
`ifdef TIMER_IRQ_MISS_CNT_EN
      .miss    (miss[i]),
`endif
      .pending (pending[i])
    );
  end

  // Read mux samples register values before this edge updates them.
  always_comb begin
    rd_val = '0;
    case (avs.address)
      ADDR_PENDING: rd_val[N_SRC-1:0] = pending;
      ADDR_MASK:    rd_val[N_SRC-1:0] = mask_q;
      ADDR_STATUS:  rd_val[0]         = irq;
      default:      ;
    endcase
`ifdef TIMER_IRQ_MISS_CNT_EN
    for (int i = 0; i < N_SRC; i++) begin
      if (avs.address == ADDR_MISS_BASE + addr_t'(i)) rd_val[MISS_W-1:0] = miss[i];
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q       <= '0;
      irq          <= 1'b0;
      avs.readdata <= '0;
    end else begin
      irq <= |(pending & mask_q);
      if (wr_en && avs.address == ADDR_MASK) mask_q <= avs.writedata[N_SRC-1:0];
      if (rd_en) avs.readdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl; inputs driven and outputs sampled on the falling clock edge.
module tb_timer_irq_ctrl;
  import timer_irq_pkg::*;

  localparam int N_SRC = 4;

  logic             clk;
  logic             reset_n;
  logic [N_SRC-1:0] tick;
  logic             irq;
  int               n_checks;
  int               n_errors;
  logic [31:0]      exp_q[$];

  timer_irq_ctrl_if avs_if ();

  timer_irq_ctrl #(.N_SRC(N_SRC), .MISS_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .avs     (avs_if),
    .irq     (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic bus_idle();
    avs_if.chipselect = 1'b0;
    avs_if.read       = 1'b0;
    avs_if.write      = 1'b0;
    avs_if.address    = '0;
    avs_if.writedata  = '0;
  endtask

  task automatic bus_wr(input addr_t a, input logic [31:0] d);
    avs_if.chipselect = 1'b1;
    avs_if.write      = 1'b1;
    avs_if.address    = a;
    avs_if.writedata  = d;
    cyc();
    bus_idle();
  endtask

  task automatic rd_expect(input string tag, input addr_t a, input logic [31:0] exp);
    exp_q.push_back(exp);
    avs_if.chipselect = 1'b1;
    avs_if.read       = 1'b1;
    avs_if.address    = a;
    cyc();
    bus_idle();
    chk(tag, avs_if.readdata, exp_q.pop_front());
  endtask

  task automatic pulse(input logic [N_SRC-1:0] t);
    tick = t;
    cyc();
    tick = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    tick     = '0;
    bus_idle();
    repeat (3) cyc();
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", avs_if.readdata, 32'h0);
    reset_n = 1'b1;
    cyc();
    rd_expect("rst_pend", ADDR_PENDING, 32'h0);
    rd_expect("rst_mask", ADDR_MASK, 32'h0);
    rd_expect("rst_status", ADDR_STATUS, 32'h0);

    // enabled source: irq two cycles after tick, drops two cycles after ack
    bus_wr(ADDR_MASK, 32'h2);
    pulse(4'h2);
    chk("irq_t1", 32'(irq), 32'h0);
    cyc();
    chk("irq_t2", 32'(irq), 32'h1);
    rd_expect("pend_src1", ADDR_PENDING, 32'h2);
    bus_wr(ADDR_ACK, 32'h2);
    chk("ack_irq_t1", 32'(irq), 32'h1);
    cyc();
    chk("ack_irq_t2", 32'(irq), 32'h0);
    rd_expect("pend_acked", ADDR_PENDING, 32'h0);

    // masked source still latches; unmasking raises irq
    bus_wr(ADDR_MASK, 32'h0);
    pulse(4'h1);
    repeat (2) cyc();
    chk("masked_irq", 32'(irq), 32'h0);
    rd_expect("masked_pend", ADDR_PENDING, 32'h1);
    bus_wr(ADDR_MASK, 32'h1);
    chk("unmask_irq_t1", 32'(irq), 32'h0);
    cyc();
    chk("unmask_irq_t2", 32'(irq), 32'h1);
    rd_expect("status_irq", ADDR_STATUS, 32'h1);

    // tick and ack of the same bit in one cycle: tick wins, no miss
`ifdef TIMER_IRQ_MISS_CNT_EN
    pulse(4'h1);
    rd_expect("miss0_one", ADDR_MISS_BASE, 32'h1);
`endif
    tick = 4'h1;
    avs_if.chipselect = 1'b1;
    avs_if.write      = 1'b1;
    avs_if.address    = ADDR_ACK;
    avs_if.writedata  = 32'h1;
    cyc();
    bus_idle();
    tick = '0;
    rd_expect("ack_tick_pend", ADDR_PENDING, 32'h1);
`ifdef TIMER_IRQ_MISS_CNT_EN
    rd_expect("ack_tick_miss0", ADDR_MISS_BASE, 32'h0);
`endif
    bus_wr(ADDR_ACK, 32'h1);
    bus_wr(ADDR_MASK, 32'h0);
    cyc();
    rd_expect("pend_clear0", ADDR_PENDING, 32'h0);
    chk("irq_clear0", 32'(irq), 32'h0);

    // ack is ineffective while a tick is held high
    tick = 4'h4;
    repeat (3) cyc();
    bus_wr(ADDR_ACK, 32'h4);
    cyc();
    tick = '0;
    rd_expect("held_pend", ADDR_PENDING, 32'h4);
    bus_wr(ADDR_ACK, 32'h4);
    rd_expect("held_cleared", ADDR_PENDING, 32'h0);

`ifdef TIMER_IRQ_MISS_CNT_EN
    tick = 4'h4;
    repeat (300) cyc();
    tick = '0;
    rd_expect("miss2_sat", ADDR_MISS_BASE + 4'd2, 32'hFF);
    bus_wr(ADDR_ACK, 32'h4);
    rd_expect("miss2_cleared", ADDR_MISS_BASE + 4'd2, 32'h0);
    rd_expect("pend2_cleared", ADDR_PENDING, 32'h0);
`endif

    // unmapped / write-only addresses
    rd_expect("rd_ack_addr", ADDR_ACK, 32'h0);
    rd_expect("rd_addr5", 4'd5, 32'h0);
    rd_expect("rd_addr9", 4'd9, 32'h0);

    // simultaneous read and write returns the old value
    bus_wr(ADDR_MASK, 32'h5);
    avs_if.chipselect = 1'b1;
    avs_if.read       = 1'b1;
    avs_if.write      = 1'b1;
    avs_if.address    = ADDR_MASK;
    avs_if.writedata  = 32'h3;
    cyc();
    bus_idle();
    chk("rw_old_mask", avs_if.readdata, 32'h5);
    rd_expect("rw_new_mask", ADDR_MASK, 32'h3);
    bus_wr(ADDR_MASK, 32'hFF);
    rd_expect("mask_upper_ignored", ADDR_MASK, 32'hF);

    // asynchronous reset in the middle of activity
    bus_wr(ADDR_MASK, 32'hF);
    pulse(4'hF);
    repeat (2) cyc();
    chk("pre_rst_irq", 32'(irq), 32'h1);
    rd_expect("pre_rst_pend", ADDR_PENDING, 32'hF);
    reset_n = 1'b0;
    #1;
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_rdata", avs_if.readdata, 32'h0);
    chk("arst_pend", 32'(dut.pending), 32'h0);
    chk("arst_mask", 32'(dut.mask_q), 32'h0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_rst_irq", 32'(irq), 32'h0);
    rd_expect("post_rst_pend", ADDR_PENDING, 32'h0);
    rd_expect("post_rst_mask", ADDR_MASK, 32'h0);
    rd_expect("post_rst_status", ADDR_STATUS, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
